multi_lane_race_official: RTL and testbench

Parametrised, multi-lane successor to the single-lane race official. It arbitrates a race among `LANES` competitors using a per-lane ready/start/done handshake. It also provides an all-lanes or any-lanes start mode, a per-race elapsed-cycle timer with timeout, and registered race results (winner index, winning time, finish and did-not-finish masks). It sits between lane stimulus/observer logic and any downstream scoreboard that consumes `result_valid`.

---
 rtl/multi_lane_race_official_if.sv | 30 +++
 rtl/multi_lane_race_official.sv | 110 +++++++++++
 tb/tb_multi_lane_race_official.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/multi_lane_race_official_if.sv
// Lane-side handshake and race-result bundle for multi_lane_race_official.
// master = lane stimulus / observer side, slave = the race official.
interface multi_lane_race_official_if #(
  parameter int LANES = 4,
  parameter int TW    = 8
);
  localparam int IW = $clog2(LANES);

  logic             mode;
  logic [LANES-1:0] ready;
  logic [LANES-1:0] done;
  logic [LANES-1:0] start;
  logic             busy;
  logic             result_valid;
  logic [IW-1:0]    winner;
  logic [TW-1:0]    winner_time;
  logic             no_winner;
  logic [LANES-1:0] finished;
  logic [LANES-1:0] dnf;

  modport master (
    output mode, ready, done,
    input  start, busy, result_valid, winner, winner_time, no_winner, finished, dnf
  );

  modport slave (
    input  mode, ready, done,
    output start, busy, result_valid, winner, winner_time, no_winner, finished, dnf
  );
endinterface

// File: rtl/multi_lane_race_official.sv
// Multi-lane race official: starts a race on all/any ready lanes, times it with a
// saturating timer and timeout, and publishes registered results for one RESULT cycle.
module multi_lane_race_official #(
  parameter int LANES   = 4,
  parameter int TW      = 8,
  parameter int TIMEOUT = 200
) (
  input logic                     clk,
  input logic                     rst,
  multi_lane_race_official_if.slave bus
);
  localparam int IW = $clog2(LANES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RACE, RESULT} state_t;

  state_t           state;
  logic [LANES-1:0] entrants;
  logic [LANES-1:0] acc;
  logic [TW-1:0]    timer;
  logic             seen;
  logic [IW-1:0]    win_idx;
  logic [TW-1:0]    win_time;

  logic             go;
  logic [LANES-1:0] newf;
  logic [LANES-1:0] acc_n;
  logic [IW-1:0]    first_idx;
  logic             claim;
  logic             race_end;

  always_comb begin
    go        = (bus.done == '0) && (bus.mode ? (bus.ready != '0) : (bus.ready == '1));
    newf      = bus.done & entrants & ~acc;
    acc_n     = acc | newf;
    first_idx = '0;
    // Descending scan so the lowest newly finishing lane wins a tie.
    for (int unsigned i = LANES; i > 0; i--) begin
      if (newf[i-1]) first_idx = IW'(i - 1);
    end
    claim    = !seen && (newf != '0);
    race_end = (acc_n == entrants) || (timer == TLAST);
  end

  // Per-race winner tracking is kept internally so published results stay stable
  // until the next RESULT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      entrants         <= '0;
      acc              <= '0;
      timer            <= '0;
      seen             <= 1'b0;
      win_idx          <= '0;
      win_time         <= '0;
      bus.start        <= '0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.winner       <= '0;
      bus.winner_time  <= '0;
      bus.no_winner    <= 1'b0;
      bus.finished     <= '0;
      bus.dnf          <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.result_valid <= 1'b0;
          if (go) begin
            entrants  <= bus.mode ? bus.ready : '1;
            bus.start <= bus.mode ? bus.ready : '1;
            acc       <= '0;
            timer     <= '0;
            seen      <= 1'b0;
            win_idx   <= '0;
            win_time  <= '0;
            bus.busy  <= 1'b1;
            state     <= RACE;
          end
        end
        RACE: begin
          acc <= acc_n;
          if (timer != '1) timer <= timer + 1'b1;
          if (claim) begin
            seen     <= 1'b1;
            win_idx  <= first_idx;
            win_time <= timer;
          end
          if (race_end) begin
            state            <= RESULT;
            bus.start        <= '0;
            bus.result_valid <= 1'b1;
            bus.finished     <= acc_n;
            bus.dnf          <= entrants & ~acc_n;
            bus.no_winner    <= (acc_n == '0);
            bus.winner       <= claim ? first_idx : win_idx;
            bus.winner_time  <= claim ? timer : win_time;
          end else begin
            bus.start <= entrants & ~acc_n;
          end
        end
        RESULT: begin
          bus.result_valid <= 1'b0;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_lane_race_official.sv
// Self-checking bench for multi_lane_race_official: table-driven races with a
// result scoreboard, plus hand-written reset, blocking-done and mid-race reset sequences.
module tb_multi_lane_race_official;
  localparam int LANES   = 4;
  localparam int TW      = 8;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_lane_race_official_if #(.LANES(LANES), .TW(TW)) bus ();

  multi_lane_race_official #(
    .LANES(LANES),
    .TW(TW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       mode;
    logic [3:0] ready;
    logic [7:0] fin [4];   // timer value at which each lane pulses done, 255 = never
    int         end_t;     // timer value of the last RACE cycle
    logic [1:0] winner;
    logic [7:0] wtime;
    logic [3:0] finished;
    logic [3:0] dnf;
    logic       nw;
  } vec_t;

  typedef struct {
    logic [1:0] winner;
    logic [7:0] wtime;
    logic [3:0] finished;
    logic [3:0] dnf;
    logic       nw;
  } res_t;

  vec_t vt [6];
  res_t sb [$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and retire any published result.
  task automatic step();
    @(negedge clk);
    if (bus.result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 32'(bus.result_valid), 32'd0);
      end else begin
        res_t r;
        r = sb.pop_front();
        chk("sb_finished", 32'(bus.finished), 32'(r.finished));
        chk("sb_dnf", 32'(bus.dnf), 32'(r.dnf));
        chk("sb_no_winner", 32'(bus.no_winner), 32'(r.nw));
        if (!r.nw) begin
          chk("sb_winner", 32'(bus.winner), 32'(r.winner));
          chk("sb_winner_time", 32'(bus.winner_time), 32'(r.wtime));
        end
      end
    end
  endtask

  task automatic run_race(input int k);
    vec_t       v;
    res_t       r;
    logic [3:0] ent;
    logic [3:0] fin_so_far;
    logic [3:0] dmask;
    v = vt[k];
    ent = v.mode ? v.ready : 4'hF;
    r.winner = v.winner; r.wtime = v.wtime; r.finished = v.finished; r.dnf = v.dnf; r.nw = v.nw;
    sb.push_back(r);
    bus.mode = v.mode; bus.ready = v.ready; bus.done = '0;
    step();
    fin_so_far = '0;
    for (int c = 0; c <= v.end_t + 1; c++) begin
      if (c <= v.end_t) begin
        chk($sformatf("r%0d_start_c%0d", k, c), 32'(bus.start), 32'(ent & ~fin_so_far));
        chk($sformatf("r%0d_busy_c%0d", k, c), 32'(bus.busy), 32'd1);
        chk($sformatf("r%0d_rv_low_c%0d", k, c), 32'(bus.result_valid), 32'd0);
      end else begin
        chk($sformatf("r%0d_rv_pulse", k), 32'(bus.result_valid), 32'd1);
        chk($sformatf("r%0d_start_result", k), 32'(bus.start), 32'd0);
        chk($sformatf("r%0d_busy_result", k), 32'(bus.busy), 32'd1);
      end
      dmask = '0;
      for (int i = 0; i < 4; i++)
        if (c <= v.end_t && int'(v.fin[i]) == c) dmask[i] = 1'b1;
      fin_so_far = fin_so_far | (dmask & ent);
      bus.done  = dmask;
      bus.ready = '0;
      step();
    end
    chk($sformatf("r%0d_idle_busy", k), 32'(bus.busy), 32'd0);
    chk($sformatf("r%0d_idle_rv", k), 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    vt[0] = '{mode:1'b0, ready:4'hF, fin:'{8'd5, 8'd5, 8'd3, 8'd5}, end_t:5,
              winner:2'd2, wtime:8'd3, finished:4'hF, dnf:4'h0, nw:1'b0};
    vt[1] = '{mode:1'b0, ready:4'hF, fin:'{8'd6, 8'd4, 8'd7, 8'd4}, end_t:7,
              winner:2'd1, wtime:8'd4, finished:4'hF, dnf:4'h0, nw:1'b0};
    vt[2] = '{mode:1'b1, ready:4'h5, fin:'{8'd7, 8'd255, 8'd255, 8'd2}, end_t:19,
              winner:2'd0, wtime:8'd7, finished:4'h1, dnf:4'h4, nw:1'b0};
    vt[3] = '{mode:1'b1, ready:4'h6, fin:'{8'd255, 8'd255, 8'd255, 8'd255}, end_t:19,
              winner:2'd0, wtime:8'd0, finished:4'h0, dnf:4'h6, nw:1'b1};
    vt[4] = '{mode:1'b0, ready:4'hF, fin:'{8'd0, 8'd0, 8'd0, 8'd0}, end_t:0,
              winner:2'd0, wtime:8'd0, finished:4'hF, dnf:4'h0, nw:1'b0};
    vt[5] = '{mode:1'b1, ready:4'hA, fin:'{8'd255, 8'd9, 8'd255, 8'd2}, end_t:9,
              winner:2'd3, wtime:8'd2, finished:4'hA, dnf:4'h0, nw:1'b0};

    rst = 1'b1; bus.mode = 1'b0; bus.ready = 4'hF; bus.done = '0;
    for (int n = 0; n < 2; n++) begin
      step();
      chk("rst_start", 32'(bus.start), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rv", 32'(bus.result_valid), 32'd0);
      chk("rst_results", {bus.winner, bus.winner_time, bus.no_winner, bus.finished, bus.dnf}, 32'd0);
    end
    bus.ready = '0;
    rst = 1'b0;
    step();

    for (int k = 0; k < 6; k++) run_race(k);

    // done held in IDLE blocks any start even with all lanes ready.
    bus.mode = 1'b0; bus.ready = 4'hF; bus.done = 4'h1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("block_busy", 32'(bus.busy), 32'd0);
      chk("block_start", 32'(bus.start), 32'd0);
    end
    bus.done = '0;
    step();
    chk("unblock_busy", 32'(bus.busy), 32'd1);
    chk("unblock_start", 32'(bus.start), 32'hF);
    bus.ready = '0;
    for (int c = 0; c < 6; c++) step();
    chk("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    chk("abort_start", 32'(bus.start), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rv", 32'(bus.result_valid), 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 25; n++) begin
      step();
      chk("abort_no_rv", 32'(bus.result_valid), 32'd0);
    end

    run_race(0);
    run_race(5);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
